// File: rtl/clock_enable_generator_pkg.sv
// Shared definitions for the clock-enable generator: FSM state encoding,
// default parameter values and the parameter legality rule.
package clock_enable_generator_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SLOW  = 2'd2
  } state_e;

  localparam int DEF_PIX_DIV   = 2;
  localparam int DEF_CNT_W     = 5;
  localparam int DEF_PROC_LOG2 = 4;
  localparam int DEF_SLOW_LOG2 = 5;
  localparam int DEF_VT_LOG2   = 3;

  function automatic bit params_legal(input int pix_div, input int cnt_w,
                                      input int proc_log2, input int slow_log2,
                                      input int vt_log2);
    return (pix_div >= 1) && (proc_log2 >= 2) && (slow_log2 >= proc_log2) &&
           (cnt_w >= slow_log2) && (vt_log2 >= 2) && (vt_log2 <= cnt_w);
  endfunction

endpackage

// File: rtl/clock_enable_generator_enable_divider.sv
// Pixel prescaler and master counter; produces the pixel tick and the
// all-ones decode pulses DIV_en[i] that every other enable is built from.
module enable_divider
  import clock_enable_generator_pkg::*;
#(
  parameter int PIX_DIV = DEF_PIX_DIV,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MC_TAP  = 0
) (
  input  logic             CLK100MHZ,
  input  logic             nRESET,
  output logic             pixel_en,
  output logic [CNT_W-1:0] div_en,
  output logic             mc_tap
);

  localparam int               PC_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PIX_DIV - 1);

  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] mc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK100MHZ) begin
    if (!nRESET) begin
      pc <= '0;
      mc <= '0;
    end else begin
      pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
      if (pixel_en) mc <= mc + CNT_W'(1);
    end
  end

  // Gated by reset so PIX_DIV=1 still yields silence while held in reset.
  assign pixel_en = nRESET & (pc == PC_LAST);
  assign mc_tap   = mc[MC_TAP];

  for (genvar i = 0; i < CNT_W; i++) begin : g_div
    assign div_en[i] = pixel_en & (&mc[i:0]);
  end

endmodule

// File: rtl/clock_enable_generator.sv
// System timing generator: pixel/divider/slow-bus enables plus the processor
// cycle FSM that stretches slow-peripheral cycles up to the slow-bus boundary.
module clock_enable_generator
  import clock_enable_generator_pkg::*;
#(
  parameter int PIX_DIV   = DEF_PIX_DIV,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PROC_LOG2 = DEF_PROC_LOG2,
  parameter int SLOW_LOG2 = DEF_SLOW_LOG2,
  parameter int VT_LOG2   = DEF_VT_LOG2
) (
  input  logic             CLK100MHZ,
  input  logic             nRESET,
  input  logic             STRETCH_req,
  output logic             PIXEL_en,
  output logic [CNT_W-1:0] DIV_en,
  output logic             PROC_en,
  output logic             SLOW_en,
  output logic             PHI_2,
  output logic             V_TURN,
  output logic             STRETCHED
);

  if (!params_legal(PIX_DIV, CNT_W, PROC_LOG2, SLOW_LOG2, VT_LOG2)) begin : g_illegal_params
    $error("clock_enable_generator: illegal parameter combination");
  end

  state_e state_q, state_d;
  logic   nom, half, mc_vt;

  enable_divider #(
    .PIX_DIV (PIX_DIV),
    .CNT_W   (CNT_W),
    .MC_TAP  (VT_LOG2 - 1)
  ) u_div (
    .CLK100MHZ (CLK100MHZ),
    .nRESET    (nRESET),
    .pixel_en  (PIXEL_en),
    .div_en    (DIV_en),
    .mc_tap    (mc_vt)
  );

  assign nom     = DIV_en[PROC_LOG2-1];
  assign half    = DIV_en[PROC_LOG2-2];
  assign SLOW_en = DIV_en[SLOW_LOG2-1];

  always_ff @(posedge CLK100MHZ) begin
    if (!nRESET) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (nom && STRETCH_req) state_d = SLOW_en ? ST_SLOW : ST_ALIGN;
      ST_ALIGN: if (SLOW_en) state_d = ST_SLOW;
      ST_SLOW:  if (SLOW_en) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // A late PROC_en only ever fires on SLOW_en, which is also a nominal boundary.
  always_comb begin
    PROC_en = 1'b0;
    case (state_q)
      ST_RUN:  PROC_en = nom & ~STRETCH_req;
      ST_SLOW: PROC_en = SLOW_en;
      default: PROC_en = 1'b0;
    endcase
  end

  assign STRETCHED = (state_q != ST_RUN);

  always_ff @(posedge CLK100MHZ) begin
    if (!nRESET) begin
      PHI_2  <= 1'b0;
      V_TURN <= 1'b0;
    end else begin
      if (PROC_en)                       PHI_2 <= 1'b0;
      else if (state_q != ST_RUN)        PHI_2 <= 1'b1;
      else if (half && !nom)             PHI_2 <= 1'b1;
      if (DIV_en[VT_LOG2-2]) V_TURN <= ~mc_vt;
    end
  end

endmodule

// File: tb/tb_clock_enable_generator.sv
// Randomized bench for clock_enable_generator: expected enables come from
// elapsed-cycle arithmetic; PROC_en pulses are checked through a scoreboard.
module tb_clock_enable_generator;

  localparam int PD   = 2;
  localparam int CW   = 5;
  localparam int PL   = 4;
  localparam int SL   = 5;
  localparam int VL   = 3;
  localparam int PCYC = PD << PL;
  localparam int SP   = PD << SL;

  logic          CLK100MHZ;
  logic          nRESET;
  logic          STRETCH_req;
  logic          PIXEL_en;
  logic [CW-1:0] DIV_en;
  logic          PROC_en;
  logic          SLOW_en;
  logic          PHI_2;
  logic          V_TURN;
  logic          STRETCHED;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int mode   = 3;
  int n_req  = 0;
  int win_lo = 1;
  int win_hi = 0;
  bit busy     = 0;
  bit checking = 0;
  bit in_reset = 0;
  int sb_q[$];

  clock_enable_generator #(
    .PIX_DIV   (PD),
    .CNT_W     (CW),
    .PROC_LOG2 (PL),
    .SLOW_LOG2 (SL),
    .VT_LOG2   (VL)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .nRESET      (nRESET),
    .STRETCH_req (STRETCH_req),
    .PIXEL_en    (PIXEL_en),
    .DIV_en      (DIV_en),
    .PROC_en     (PROC_en),
    .SLOW_en     (SLOW_en),
    .PHI_2       (PHI_2),
    .V_TURN      (V_TURN),
    .STRETCHED   (STRETCHED)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Cycle k counts clocks since reset release; pixel tick n lands on k = n*PD-1.
  function automatic bit is_nom(input int k);
    return ((k + 1) % PCYC) == 0;
  endfunction

  function automatic bit is_slow(input int k);
    return ((k + 1) % SP) == 0;
  endfunction

  function automatic logic [CW+4:0] expected_outputs(input int k);
    logic [CW-1:0] d;
    bit pix, in_win, phi, vt;
    pix = ((k + 1) % PD) == 0;
    for (int i = 0; i < CW; i++) d[i] = pix && ((((k / PD) + 1) % (1 << (i + 1))) == 0);
    in_win = (k >= win_lo) && (k <= win_hi);
    phi    = in_win || ((k % PCYC) >= (PCYC / 2));
    vt     = (((k / PD) >> (VL - 1)) & 1) == 1;
    return {pix, d, d[SL-1], phi, vt, in_win};
  endfunction

  // Requester: holds STRETCH_req through its stretch, toggles it freely between boundaries.
  task automatic plan_cycle();
    bit req, slow;
    if (busy && cyc > win_hi) busy = 0;
    if (busy) begin
      STRETCH_req = 1'b1;
    end else if (is_nom(cyc)) begin
      slow = is_slow(cyc);
      case (mode)
        0:       req = ($urandom_range(0, 2) == 0);
        1:       req = !slow;
        2:       req = slow;
        default: req = 1'b0;
      endcase
      STRETCH_req = req;
      if (req) begin
        busy   = 1;
        n_req++;
        win_lo = cyc + 1;
        win_hi = slow ? cyc + SP : cyc + SP - ((cyc + 1) % SP) + SP;
        sb_q.push_back(win_hi);
        if (mode != 0) mode = 3;
      end else begin
        sb_q.push_back(cyc);
      end
    end else begin
      STRETCH_req = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
    if (nRESET) begin
      cyc++;
      plan_cycle();
    end
  endtask

  task automatic do_reset(input int n);
    checking    = 0;
    nRESET      = 1'b0;
    STRETCH_req = 1'b0;
    busy        = 0;
    win_lo      = 1;
    win_hi      = 0;
    sb_q.delete();
    repeat (n) begin
      @(posedge CLK100MHZ);
      #1;
      in_reset = 1;
    end
    nRESET   = 1'b1;
    in_reset = 0;
    cyc      = 0;
    checking = 1;
    plan_cycle();
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    repeat (n) tick();
  endtask

  task automatic run_stretch(input int m, input string name);
    int start;
    bit done;
    start = n_req;
    mode  = m;
    done  = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = (n_req > start) && !busy;
    end
    check(name, int'(done), 1);
  endtask

  always @(negedge CLK100MHZ) begin
    if (in_reset) begin
      check("reset_outputs",
            int'(32'({PIXEL_en, DIV_en, PROC_en, SLOW_en, PHI_2, V_TURN, STRETCHED})), 0);
    end else if (checking) begin
      check("outputs", int'(32'({PIXEL_en, DIV_en, SLOW_en, PHI_2, V_TURN, STRETCHED})),
            int'(32'(expected_outputs(cyc))));
      if (sb_q.size() > 0 && sb_q[0] < cyc) begin
        check("proc_en_missing", cyc, sb_q[0]);
        void'(sb_q.pop_front());
      end
      if (PROC_en) begin
        int exp_cyc;
        exp_cyc = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
        check("proc_en_cycle", cyc, exp_cyc);
      end
    end
  end

  initial begin
    int start;
    nRESET      = 1'b0;
    STRETCH_req = 1'b0;
    do_reset(3);
    run(3, 1000);
    run_stretch(1, "stretch_via_align");
    run_stretch(2, "stretch_at_slow");
    run(0, 4000);
    run_stretch(1, "stretch_after_random");

    start = n_req;
    mode  = 1;
    for (int i = 0; i < 200 && n_req == start; i++) tick();
    check("align_entered", int'(n_req > start), 1);
    repeat (4) tick();
    do_reset(3);
    run(3, 200);
    run_stretch(2, "stretch_after_reset");

    mode = 3;
    for (int i = 0; i < 300 && busy; i++) tick();
    repeat (2) tick();
    @(negedge CLK100MHZ);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
